// File: rtl/alu_mc.sv
// alu_mc: registered WIDTH-bit 16-op ALU with a valid/ready handshake.
// Multiply is a radix-2 shift-add sequence; every other op retires in one cycle.
module alu_mc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   x_d, y_d;
  logic               zero_d;
  logic               in_ready_d, out_valid_d;

  logic               accept;
  logic [PW-1:0]      alu_res;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [WIDTH-1:0]   not_w, shr_w;
  logic [PW-1:0]      shl_w;

  assign accept = in_valid & in_ready;

  // Width-exact intermediates so carry/borrow land on bit WIDTH and nothing above.
  // Shifts by >= operand width yield zero by language definition.
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign not_w  = ~a;
  assign shr_w  = a >> b;
  assign shl_w  = PW'(a) << b;

  // Single-cycle result in {y,x} form; unused bits stay zero.
  always_comb begin
    alu_res = '0;
    case (opcode)
      4'b0000: alu_res[0] = |a;
      4'b0001: alu_res[0] = &a;
      4'b0010: alu_res[0] = ^a;
      4'b0011: alu_res    = PW'(a & b);
      4'b0100: alu_res    = PW'(a | b);
      4'b0101: alu_res    = PW'(a ^ b);
      4'b0110: alu_res[0] = (a > b);
      4'b0111: alu_res[0] = (a < b);
      4'b1000: alu_res[0] = (a == '0);
      4'b1001: alu_res[0] = (a == b);
      4'b1010: alu_res    = PW'(sum_w);
      4'b1011: alu_res    = PW'(diff_w);
      4'b1100: alu_res    = '0;
      4'b1101: alu_res    = PW'(shr_w);
      4'b1110: alu_res    = shl_w;
      4'b1111: alu_res    = PW'(not_w);
    endcase
  end

  // Next-state and datapath: results hold their value outside of retirement.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    x_d      = x;
    y_d      = y;
    zero_d   = zero;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == 4'b1100) begin
            mcand_d  = PW'(a);
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            {y_d, x_d} = alu_res;
            zero_d     = (alu_res == '0);
            state_d    = HOLD;
          end
        end
      end
      MUL: begin
        // WIDTH shift-add iterations, then one cycle to publish the product.
        if (cnt_q == CNT_W'(WIDTH)) begin
          {y_d, x_d} = acc_q;
          zero_d     = (acc_q == '0);
          state_d    = HOLD;
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      x         <= '0;
      y         <= '0;
      zero      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      x         <= x_d;
      y         <= y_d;
      zero      <= zero_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule
